// File: rtl/demux_pkg.sv
// Shared types and sizing for the 1-to-WIDTH demultiplexer/deserializer.
// Imported by the decoder and the top level.
package demux_pkg;

   localparam int DEMUX_WIDTH = 8;
   localparam int DEMUX_SEL_W = $clog2(DEMUX_WIDTH);

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_e;

endpackage

// File: rtl/demux_decoder.sv
// Select-to-one-hot decoder with enable.
// Drives the per-bit write enables of the output and shadow registers.
module demux_decoder
   import demux_pkg::*;
#(
   parameter int WIDTH = DEMUX_WIDTH,
   parameter int SEL_W = $clog2(WIDTH)
) (
   input  logic [SEL_W-1:0] sel_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      if (en_i) begin
         onehot_o[sel_i] = 1'b1;
      end
   end

endmodule

// File: rtl/demux_deserializer.sv
// Serial bit steering into a parallel word: manual index or auto counter,
// with a valid/ready output and a one-word shadow for back-pressure.
module demux_deserializer
   import demux_pkg::*;
#(
   parameter int WIDTH = DEMUX_WIDTH,
   parameter int SEL_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic [SEL_W-1:0] S,
   input  logic             D,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] O,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SEL_W-1:0] bit_cnt
);

   state_e           state_q, state_d;
   logic             mode_q, mode_d;
   logic [SEL_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [WIDTH-1:0] o_q, o_d;
   logic             ov_q, ov_d;

   logic             collect;
   logic             mode_chg;
   logic [SEL_W-1:0] cnt_eff;
   logic [WIDTH-1:0] shadow_eff;
   logic [WIDTH-1:0] shadow_wr;
   logic [WIDTH-1:0] man_we;
   logic [WIDTH-1:0] sh_we;
   logic             beat;
   logic             man_beat;
   logic             auto_beat;
   logic             xfer;
   logic             last;

   // A mode change drops the partial word; the beat in that cycle sees an empty one.
   assign collect    = (state_q == COLLECT);
   assign mode_chg   = collect & (mode != mode_q);
   assign cnt_eff    = mode_chg ? '0 : cnt_q;
   assign shadow_eff = mode_chg ? '0 : shadow_q;

   always_comb begin
      in_ready = 1'b0;
      if (collect) begin
         in_ready = mode | ~ov_q;
      end
   end

   assign beat      = in_valid & in_ready;
   assign man_beat  = beat & ~mode;
   assign auto_beat = beat & mode;
   assign xfer      = ov_q & out_ready;
   assign last      = (cnt_eff == SEL_W'(WIDTH - 1));

   demux_decoder #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W)
   ) u_man_dec (
      .sel_i    (S),
      .en_i     (man_beat),
      .onehot_o (man_we)
   );

   demux_decoder #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W)
   ) u_sh_dec (
      .sel_i    (cnt_eff),
      .en_i     (auto_beat),
      .onehot_o (sh_we)
   );

   assign shadow_wr = (shadow_eff & ~sh_we) | ({WIDTH{D}} & sh_we);

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      o_d      = o_q;
      ov_d     = ov_q;
      if (xfer) begin
         ov_d = 1'b0;
      end
      unique case (state_q)
         COLLECT: begin
            mode_d   = mode;
            cnt_d    = cnt_eff;
            shadow_d = shadow_wr;
            o_d      = (o_q & ~man_we) | ({WIDTH{D}} & man_we);
            if (auto_beat) begin
               cnt_d = cnt_eff + SEL_W'(1);
               if (last) begin
                  if (!ov_q || out_ready) begin
                     o_d  = shadow_wr;
                     ov_d = 1'b1;
                  end else begin
                     state_d = HOLD;
                  end
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               o_d     = shadow_q;
               ov_d    = 1'b1;
               state_d = COLLECT;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= COLLECT;
         mode_q   <= 1'b0;
         cnt_q    <= '0;
         shadow_q <= '0;
         o_q      <= '0;
         ov_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         o_q      <= o_d;
         ov_q     <= ov_d;
      end
   end

   assign O         = o_q;
   assign out_valid = ov_q;
   assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_demux_deserializer.sv
// Bench for demux_deserializer: vector table, directed corner sequences,
// and random traffic against a word-level reference model.
module tb_demux_deserializer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mode = 1'b0;
   logic [2:0] S = '0;
   logic       D = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] O;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [2:0] bit_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   demux_deserializer dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .S         (S),
      .D         (D),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .O         (O),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bit_cnt   (bit_cnt)
   );

   // Reference model: bits gathered so far, plus an optional parked word.
   logic [7:0] m_o;
   logic       m_ov;
   logic       m_hold;
   logic [7:0] m_word;
   logic       m_mode;
   bit         m_bits[$];

   function automatic logic m_ready(input logic md);
      if (m_hold) return 1'b0;
      return md ? 1'b1 : !m_ov;
   endfunction

   task automatic model_step(input logic r, input logic md, input logic [2:0] s,
                             input logic d, input logic iv, input logic ordy);
      logic       rdy;
      logic       done;
      logic [7:0] w;
      if (r) begin
         m_o = '0; m_ov = 0; m_hold = 0; m_word = '0; m_mode = 0;
         m_bits.delete();
         return;
      end
      if (m_hold) begin
         if (ordy) begin
            m_o = m_word;
            m_hold = 0;
         end
         return;
      end
      if (md != m_mode) begin
         m_bits.delete();
         m_mode = md;
      end
      rdy  = m_ready(md);
      done = 0;
      if (iv && rdy && !md) m_o[s] = d;
      if (iv && rdy && md) begin
         m_bits.push_back(d);
         if (m_bits.size() == 8) begin
            for (int i = 0; i < 8; i++) w[i] = m_bits[i];
            m_bits.delete();
            if (!m_ov || ordy) begin
               m_o = w; m_ov = 1; done = 1;
            end else begin
               m_word = w; m_hold = 1;
            end
         end
      end
      if (m_ov && ordy && !done && !m_hold) m_ov = 0;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] o, input logic ov,
                          input logic [2:0] cnt, input logic rdy);
      chk({tag, ".O"}, O, o);
      chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, ov});
      chk({tag, ".bit_cnt"}, {5'd0, bit_cnt}, {5'd0, cnt});
      chk({tag, ".in_ready"}, {7'd0, in_ready}, {7'd0, rdy});
   endtask

   task automatic step(input logic r, input logic md, input logic [2:0] s,
                       input logic d, input logic iv, input logic ordy);
      @(negedge clk);
      rst = r; mode = md; S = s; D = d; in_valid = iv; out_ready = ordy;
      @(posedge clk);
      model_step(r, md, s, d, iv, ordy);
      #1;
   endtask

   task automatic beats_auto(input logic [7:0] w, input logic ordy);
      for (int i = 0; i < 8; i++) step(0, 1, 3'd0, w[i], 1, ordy);
   endtask

   typedef struct {
      logic       r;
      logic       md;
      logic [2:0] s;
      logic       d;
      logic       iv;
      logic       ordy;
      logic [7:0] o;
      logic       ov;
      logic [2:0] cnt;
      logic       rdy;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic md, input logic [2:0] s,
                               input logic d, input logic iv, input logic ordy,
                               input logic [7:0] o, input logic ov,
                               input logic [2:0] cnt, input logic rdy);
      vec_t v;
      v.r = r; v.md = md; v.s = s; v.d = d; v.iv = iv; v.ordy = ordy;
      v.o = o; v.ov = ov; v.cnt = cnt; v.rdy = rdy;
      return v;
   endfunction

   vec_t vecs[$];

   initial begin
      logic [7:0] pat;
      pat = 8'h42;
      // reset, manual beats, then an auto word with out_ready high
      vecs.push_back(mk(1, 0, 3'd0, 0, 0, 0, 8'h00, 0, 3'd0, 1));
      vecs.push_back(mk(1, 0, 3'd0, 0, 0, 0, 8'h00, 0, 3'd0, 1));
      vecs.push_back(mk(0, 0, 3'd5, 1, 1, 0, 8'h20, 0, 3'd0, 1));
      vecs.push_back(mk(0, 0, 3'd1, 1, 1, 0, 8'h22, 0, 3'd0, 1));
      vecs.push_back(mk(0, 0, 3'd1, 0, 1, 0, 8'h20, 0, 3'd0, 1));
      for (int i = 0; i < 7; i++)
         vecs.push_back(mk(0, 1, 3'd0, pat[i], 1, 1, 8'h20, 0, 3'(i + 1), 1));
      vecs.push_back(mk(0, 1, 3'd0, pat[7], 1, 1, 8'h42, 1, 3'd0, 1));
      vecs.push_back(mk(0, 1, 3'd0, 0, 0, 1, 8'h42, 0, 3'd0, 1));
      vecs.push_back(mk(0, 1, 3'd0, 0, 0, 0, 8'h42, 0, 3'd0, 1));

      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].md, vecs[i].s, vecs[i].d, vecs[i].iv, vecs[i].ordy);
         chk_all($sformatf("vec%0d", i), vecs[i].o, vecs[i].ov, vecs[i].cnt, vecs[i].rdy);
      end

      // back-pressure: second word parks in the shadow
      beats_auto(8'hFF, 0);
      chk_all("bp_first", 8'hFF, 1, 3'd0, 1);
      beats_auto(8'hAA, 0);
      chk_all("bp_hold", 8'hFF, 1, 3'd0, 0);
      step(0, 1, 3'd0, 0, 0, 1);
      chk_all("bp_release", 8'hAA, 1, 3'd0, 1);
      step(0, 1, 3'd0, 0, 0, 1);
      chk_all("bp_drain", 8'hAA, 0, 3'd0, 1);

      // mode toggle drops a partial word
      for (int i = 0; i < 3; i++) step(0, 1, 3'd0, 1, 1, 0);
      chk_all("mc_partial", 8'hAA, 0, 3'd3, 1);
      step(0, 0, 3'd0, 0, 0, 0);
      chk_all("mc_toggle", 8'hAA, 0, 3'd0, 1);
      beats_auto(8'h5C, 1);
      chk_all("mc_word", 8'h5C, 1, 3'd0, 1);
      step(0, 1, 3'd0, 0, 0, 1);
      chk_all("mc_drain", 8'h5C, 0, 3'd0, 1);

      // reset mid-word and while holding
      for (int i = 0; i < 3; i++) step(0, 1, 3'd0, 1, 1, 0);
      step(1, 1, 3'd0, 1, 1, 0);
      chk_all("rst_mid", 8'h00, 0, 3'd0, 1);
      beats_auto(8'hC3, 0);
      beats_auto(8'h3C, 0);
      chk_all("rst_prehold", 8'hC3, 1, 3'd0, 0);
      step(1, 1, 3'd0, 0, 0, 0);
      chk_all("rst_hold", 8'h00, 0, 3'd0, 1);
      beats_auto(8'h81, 1);
      chk_all("rst_next", 8'h81, 1, 3'd0, 1);

      // random traffic against the model
      step(1, 0, 3'd0, 0, 0, 0);
      for (int c = 0; c < 3000; c++) begin
         logic md;
         md = ($urandom_range(0, 15) == 0) ? ~mode : mode;
         step(($urandom_range(0, 249) == 0), md, 3'($urandom_range(0, 7)),
              1'($urandom), ($urandom_range(0, 9) < 7), 1'($urandom));
         chk_all($sformatf("rnd%0d", c), m_o, m_ov, 3'(m_bits.size()),
                 m_ready(mode));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
